// File: rtl/uart_tx_arb_pkg.sv
// Shared types and helpers for the UART TX arbiter.
// Frame length depends on UART_TX_ARB_CHECKSUM_EN (trailing XOR byte when defined).
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HEADER   = 2'd1,
    ST_PAYLOAD  = 2'd2,
    ST_CHECKSUM = 2'd3
  } arb_state_t;

  // Header byte layout: tag in the upper nibble, requester id in the lower nibble
  localparam int HDR_TAG_W = 4;
  localparam int HDR_ID_W  = 4;

  function automatic logic [7:0] make_header(input logic [HDR_TAG_W-1:0] tag,
                                             input logic [HDR_ID_W-1:0]  id);
    return {tag, id};
  endfunction

  function automatic int frame_len(input int word_bytes);
`ifdef UART_TX_ARB_CHECKSUM_EN
    return word_bytes + 2;
`else
    return word_bytes + 1;
`endif
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set request at or after rr_ptr, wrapping.
module uart_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [PTR_W-1:0]   winner,
  output logic               any_req
);

  logic [PTR_W-1:0] cand;

  // Walk from the farthest offset down so the nearest set request wins last.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter framing one requester word at a time onto a UART TX byte stream.
// Define UART_TX_ARB_CHECKSUM_EN to append an XOR checksum byte to every frame.
//
// state       | meaning
// ST_IDLE     | no frame in flight; arbitrate on any request
// ST_HEADER   | presenting header {HEADER_TAG, winner}
// ST_PAYLOAD  | presenting payload bytes, most significant first
// ST_CHECKSUM | presenting XOR of header and payload (checksum build only)
module uart_tx_arbiter
  import uart_tx_arb_pkg::*;
#(
  parameter int         NUM_REQ    = 4,
  parameter int         WORD_BYTES = 2,
  parameter logic [3:0] HEADER_TAG = 4'hA
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*WORD_BYTES*8-1:0] payload,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int WORD_W = WORD_BYTES * 8;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);

  arb_state_t       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] winner;
  logic             any_req;
  logic [WORD_W-1:0] word_sr;
  logic [WORD_W-1:0] win_word;
  logic [IDX_W-1:0] idx;
  logic [7:0]       hdr;
  logic             handshake;
`ifdef UART_TX_ARB_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  uart_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  assign handshake = out_valid & out_ready;
  assign hdr       = make_header(HEADER_TAG, 4'(winner));

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) win_word = payload[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_byte  <= 8'h00;
      word_sr   <= '0;
      idx       <= '0;
`ifdef UART_TX_ARB_CHECKSUM_EN
      csum      <= 8'h00;
`endif
    end else begin
      grant <= '0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            grant     <= NUM_REQ'(1) << winner;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            out_byte  <= hdr;
            word_sr   <= win_word;
            rr_ptr    <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
            state     <= ST_HEADER;
`ifdef UART_TX_ARB_CHECKSUM_EN
            csum      <= hdr;
`endif
          end
        end
        ST_HEADER: begin
          if (handshake) begin
            out_byte <= word_sr[WORD_W-1 -: 8];
            word_sr  <= word_sr << 8;
            idx      <= '0;
            state    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (handshake) begin
            if (idx == LAST_IDX) begin
`ifdef UART_TX_ARB_CHECKSUM_EN
              // out_byte is the last payload byte; fold it in on the way out
              out_byte  <= csum ^ out_byte;
              state     <= ST_CHECKSUM;
`else
              out_valid <= 1'b0;
              busy      <= 1'b0;
              state     <= ST_IDLE;
`endif
            end else begin
              out_byte <= word_sr[WORD_W-1 -: 8];
              word_sr  <= word_sr << 8;
              idx      <= idx + 1'b1;
`ifdef UART_TX_ARB_CHECKSUM_EN
              csum     <= csum ^ out_byte;
`endif
            end
          end
        end
`ifdef UART_TX_ARB_CHECKSUM_EN
        ST_CHECKSUM: begin
          if (handshake) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end
`endif
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: byte-queue frame model checked every cycle plus directed literal checks.
module tb_uart_tx_arbiter;
  import uart_tx_arb_pkg::*;

  localparam int NR = 4;
  localparam int WB = 2;
`ifdef UART_TX_ARB_CHECKSUM_EN
  localparam int FL  = 4;
  localparam int FL1 = 3;
`else
  localparam int FL  = 3;
  localparam int FL1 = 2;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [NR-1:0]      req;
  logic [NR*WB*8-1:0] payload;
  logic [NR-1:0]      grant;
  logic               busy;
  logic [7:0]         out_byte;
  logic               out_valid;
  logic               out_ready;

  logic [NR-1:0]      req1;
  logic [NR*8-1:0]    payload1;
  logic [NR-1:0]      grant1;
  logic               busy1;
  logic [7:0]         byte1;
  logic               valid1;
  logic               ready1;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(NR), .WORD_BYTES(WB), .HEADER_TAG(4'hA)) dut (
    .clock(clock), .reset(reset), .req(req), .payload(payload), .grant(grant),
    .busy(busy), .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready)
  );

  uart_tx_arbiter #(.NUM_REQ(NR), .WORD_BYTES(1), .HEADER_TAG(4'hA)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .payload(payload1), .grant(grant1),
    .busy(busy1), .out_byte(byte1), .out_valid(valid1), .out_ready(ready1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] g);
    for (int i = 0; i < NR; i++) if (g[i]) return i;
    return -1;
  endfunction

  // Model: a frame is just a queue of bytes still to be accepted.
  logic [7:0]    mq[$];
  int            m_rr = 0;
  logic [NR-1:0] m_grant = '0;
  logic [7:0]    m_h, m_x, m_b;
  int            m_w;
  logic [7:0]    log_q[$];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_rr    = 0;
      m_grant = '0;
    end else begin
      m_grant = '0;
      if (mq.size() == 0) begin
        if (req != 0) begin
          m_w = -1;
          for (int k = 0; k < NR; k++)
            if (m_w < 0 && req[(m_rr + k) % NR]) m_w = (m_rr + k) % NR;
          m_h = {4'hA, 4'(m_w)};
          mq.push_back(m_h);
          m_x = m_h;
          for (int b = WB - 1; b >= 0; b--) begin
            m_b = payload[m_w*WB*8 + b*8 +: 8];
            mq.push_back(m_b);
            m_x = m_x ^ m_b;
          end
`ifdef UART_TX_ARB_CHECKSUM_EN
          mq.push_back(m_x);
`endif
          m_grant[m_w] = 1'b1;
          m_rr = (m_w + 1) % NR;
        end
      end else if (out_ready) begin
        void'(mq.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("valid", out_valid, mq.size() != 0);
      check("busy", busy, mq.size() != 0);
      check("grant", grant, m_grant);
      if (mq.size() != 0) check("byte", out_byte, mq[0]);
      if (out_valid && out_ready) log_q.push_back(out_byte);
    end
  end

  task automatic wait_grant(output int g);
    g = -1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock); #1;
      if (grant != 0) begin
        g = oh_idx(grant);
        break;
      end
    end
    if (g < 0) check("grant_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clock); #1;
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check("idle_timeout", 0, 1);
  endtask

  int gidx[$];
  int gcyc[$];
  logic [7:0] b1[$];

  initial begin
    int g;
    int stall;
    bit stalled;
    req       = '0;
    req1      = '0;
    out_ready = 1'b1;
    ready1    = 1'b1;
    payload   = {16'h5A5A, 16'h1234, 16'hBEEF, 16'hC0DE};
    payload1  = {8'h00, 8'h00, 8'h5A, 8'h00};
    #2;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_byte", out_byte, 8'h00);
    check("rst_valid1", valid1, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // All four requesting, with a stall on the second payload byte of frame two
    log_q.delete();
    req = 4'hF;
    stall = 0;
    stalled = 0;
    for (int c = 0; c < 300 && gidx.size() < 5; c++) begin
      @(posedge clock); #1;
      if (grant != 0) begin
        gidx.push_back(oh_idx(grant));
        gcyc.push_back(c);
        if (gidx.size() == 5) req = '0;
      end
      if (!stalled && log_q.size() == FL + 2) begin
        stalled = 1;
        stall = 5;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        check("stall_valid", out_valid, 1);
        check("stall_byte", out_byte, 8'hEF);
        stall--;
      end else begin
        out_ready = 1'b1;
      end
    end
    out_ready = 1'b1;
    wait_idle();
    check("rr_count", gidx.size(), 5);
    if (gidx.size() == 5) begin
      check("rr_g0", gidx[0], 0);
      check("rr_g1", gidx[1], 1);
      check("rr_g2", gidx[2], 2);
      check("rr_g3", gidx[3], 3);
      check("rr_g4", gidx[4], 0);
      check("gap_f1", gcyc[1] - gcyc[0], FL + 1);
      check("gap_stalled", gcyc[2] - gcyc[1], FL + 6);
      check("gap_f3", gcyc[3] - gcyc[2], FL + 1);
    end
    check("rr_bytes", log_q.size(), 5 * FL);
    if (log_q.size() >= FL + 4) begin
      check("stall_once", log_q[FL+2], 8'hEF);
`ifdef UART_TX_ARB_CHECKSUM_EN
      check("after_stall", log_q[FL+3], 8'hF0);
`else
      check("after_stall", log_q[FL+3], 8'hA2);
`endif
    end

    // Single requester 2
    log_q.delete();
    req = 4'b0100;
    wait_grant(g);
    req = '0;
    check("single_grant", g, 2);
    wait_idle();
    check("single_len", log_q.size(), FL);
    if (log_q.size() >= 3) begin
      check("single_b0", log_q[0], 8'hA2);
      check("single_b1", log_q[1], 8'h12);
      check("single_b2", log_q[2], 8'h34);
`ifdef UART_TX_ARB_CHECKSUM_EN
      if (log_q.size() >= 4) check("single_b3", log_q[3], 8'h84);
`endif
    end
    check("model_rr", m_rr, 3);

    // Wrap from rr_ptr=3
    log_q.delete();
    req = 4'b1001;
    wait_grant(g);
    check("wrap_first", g, 3);
    wait_grant(g);
    check("wrap_second", g, 0);
    req = '0;
    wait_idle();
    check("wrap_len", log_q.size(), 2 * FL);
    if (log_q.size() == 2 * FL) begin
      check("wrap_h0", log_q[0], 8'hA3);
      check("wrap_h1", log_q[FL], 8'hA0);
    end

    // Reset in the middle of a payload
    req = 4'b0001;
    wait_grant(g);
    req = '0;
    @(posedge clock); #1;
    check("pre_rst_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_grant", grant, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    log_q.delete();
    req = 4'b0001;
    wait_grant(g);
    req = '0;
    check("post_rst_grant", g, 0);
    wait_idle();
    check("post_rst_len", log_q.size(), FL);
    if (log_q.size() >= 1) check("post_rst_hdr", log_q[0], 8'hA0);

    // One-byte payload on the second instance
    req1 = 4'b0010;
    for (int c = 0; c < 50; c++) begin
      @(posedge clock); #1;
      if (grant1 != 0) break;
    end
    check("w1_grant", grant1, 4'b0010);
    req1 = '0;
    for (int c = 0; c < 10; c++) begin
      if (!valid1) break;
      b1.push_back(byte1);
      @(posedge clock); #1;
    end
    check("w1_busy_after", busy1, 0);
    check("w1_valid_after", valid1, 0);
    check("w1_len", b1.size(), FL1);
    if (b1.size() >= 2) begin
      check("w1_b0", b1[0], 8'hA1);
      check("w1_b1", b1[1], 8'h5A);
`ifdef UART_TX_ARB_CHECKSUM_EN
      if (b1.size() >= 3) check("w1_b2", b1[2], 8'hFB);
`endif
    end

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
